pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/riscv_pipe_pkg.sv | 14 +
 rtl/pipe_skid_buf.sv | 36 +++
 rtl/pipeline_stage_reg.sv | 119 +++++++++++
 tb/tb_pipeline_stage_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline stage registers: NOP encoding,
// stage occupancy states and performance counter width.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of the pipeline stage: one payload register plus a
// valid flag, loaded when the main entry is busy and cleared when drained.
module pipe_skid_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Payload only moves on load so the register never toggles while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (i_clear) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with stall and flush.
// Define PIPE_STAGE_PERF_CNT_EN to build the saturating stall/flush counters.
module pipeline_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {32'h0, NOP_INSTR}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_state_e      r_state, w_stateNext;
  logic [DATA_W-1:0] r_mainData;
  logic [DATA_W-1:0] w_skidData;
  logic              w_skidValid;
  logic              w_accept, w_consume;
  logic              w_loadMainIn, w_loadMainSkid, w_loadSkid;

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = out_valid ? r_mainData : NOP_VALUE;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (flush) begin
      w_stateNext = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_stateNext  = ONE;
            w_loadMainIn = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && !w_consume) begin
            w_stateNext = TWO;
            w_loadSkid  = 1'b1;
          end else if (w_consume && !w_accept) begin
            w_stateNext = EMPTY;
          end else if (w_accept && w_consume) begin
            w_loadMainIn = 1'b1;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_stateNext    = ONE;
            w_loadMainSkid = w_skidValid;
          end
        end
        default: w_stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mainData <= NOP_VALUE;
    end else if (w_loadMainIn) begin
      r_mainData <= in_data;
    end else if (w_loadMainSkid) begin
      r_mainData <= w_skidData;
    end
  end

  pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_loadSkid),
    .i_clear (w_loadMainSkid | flush),
    .i_data  (in_data),
    .o_valid (w_skidValid),
    .o_data  (w_skidData)
  );

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (stall && out_valid && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (flush && (r_flushCnt != '1))              r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: directed scenarios plus random
// traffic compared against a queue-based model of the two-entry stage.
module tb_pipeline_stage_reg;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        stall;
  logic        flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic [63:0] modelQ[$];
  logic [31:0] expStall;
  logic [31:0] expFlush;
  int          checks;
  int          passes;

  pipeline_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall     (stall),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  // Compare every output with what the queue model says the stage holds.
  task automatic checkState(input string tag);
    checkOutput({tag, ".outValid"}, 64'(out_valid), 64'(modelQ.size() > 0));
    checkOutput({tag, ".outData"}, out_data, (modelQ.size() > 0) ? modelQ[0] : NOP);
    checkOutput({tag, ".inReady"}, 64'(in_ready), 64'(modelQ.size() < 2));
    checkOutput({tag, ".stallCnt"}, 64'(stall_cnt), 64'(expStall));
    checkOutput({tag, ".flushCnt"}, 64'(flush_cnt), 64'(expFlush));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic iv, input logic [63:0] data, input logic ordy,
                               input logic stl, input logic fl, input string tag);
    bit acc, con;
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    acc = iv && (modelQ.size() < 2);
    con = (modelQ.size() > 0) && ordy && !stl;
`ifdef PIPE_STAGE_PERF_CNT_EN
    if (stl && (modelQ.size() > 0) && (expStall != SAT)) expStall = expStall + 1;
    if (fl && (expFlush != SAT)) expFlush = expFlush + 1;
`endif
    @(posedge clk);
    if (fl) begin
      modelQ.delete();
    end else begin
      if (con) void'(modelQ.pop_front());
      if (acc) modelQ.push_back(data);
    end
    #1;
    checkState(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    passes    = 0;
    expStall  = '0;
    expFlush  = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;

    #3;
    checkState("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming: payloads 1..4 emerge one cycle after acceptance.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b1, 1'b0, 1'b0, "stream");
      checkOutput("stream.data", out_data, 64'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, "streamDrain");

    // Backpressure: A and B fill both entries, C waits upstream.
    applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, "bpA");
    applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, "bpB");
    checkOutput("bp.full", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, "bpCheld");
    applyStimulus(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, "bpDrainA");
    checkOutput("bp.second", out_data, 64'hB);
    applyStimulus(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, "bpAcceptC");
    checkOutput("bp.third", out_data, 64'hC);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, "bpDrainC");

    // Stall: held payload stays visible for three stalled cycles.
    applyStimulus(1'b1, 64'h55, 1'b0, 1'b0, 1'b0, "stallLoad");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, "stall");
      checkOutput("stall.data", out_data, 64'h55);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, "stallRelease");

    // Flush from TWO with a payload offered in the flush cycle.
    applyStimulus(1'b1, 64'h111, 1'b0, 1'b0, 1'b0, "flushFill1");
    applyStimulus(1'b1, 64'h222, 1'b0, 1'b0, 1'b0, "flushFill2");
    applyStimulus(1'b1, 64'h333, 1'b1, 1'b0, 1'b1, "flush");
    checkOutput("flush.data", out_data, NOP);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, "flushAfter");

    // Asynchronous reset pulse in the middle of a transfer.
    applyStimulus(1'b1, 64'h444, 1'b0, 1'b1, 1'b0, "rstFill1");
    applyStimulus(1'b1, 64'h555, 1'b0, 1'b0, 1'b0, "rstFill2");
    #2 reset = 1'b1;
    #1;
    modelQ.delete();
    expStall = '0;
    expFlush = '0;
    checkState("rstAsync");
    #1 reset = 1'b0;
    applyStimulus(1'b1, 64'hABC, 1'b0, 1'b0, 1'b0, "rstFirst");
    checkOutput("rstFirst.data", out_data, 64'hABC);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, "rstDrain");

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 15) == 0), "random");
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, "randomEnd");

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Saturation: preset the stall counter just below its limit.
    applyStimulus(1'b1, 64'h77, 1'b0, 1'b0, 1'b0, "satLoad");
    force dut.r_stallCnt = 32'hFFFF_FFFE;
    #1 release dut.r_stallCnt;
    expStall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, "sat");
    checkOutput("sat.stallCnt", 64'(stall_cnt), 64'(SAT));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
